fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode constants: opcode field layout, halt opcode, default PC step.
package fetch_unit_pkg;

  localparam int          DATA_W_DEF  = 16;
  localparam int          ADDR_W_DEF  = 16;
  localparam int          PC_STEP_DEF = 2;
  localparam int          OPCODE_W    = 4;
  localparam logic [3:0]  OP_HALT     = 4'b1111;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr}; registered head, no bypass (push visible next cycle).
// Flush empties it in one cycle; caller guarantees no push while full unless popping.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited pipelined imem requests into a prefetch queue.
// Response-to-decoder latency 1 cycle; issue stops when queue + in-flight reach DEPTH.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = PC_STEP_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              hlt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + DATA_W;

  typedef logic [CW-1:0] cnt_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] resp_pc;
  cnt_t              outstanding;
  cnt_t              drop;
  cnt_t              count;
  logic              halt_seen;
  logic              q_full, q_empty;
  logic [QW-1:0]     head;
  logic [CW:0]       credit;
  logic              run, redirect, accept, rsp, push, pop, head_halt, rdata_halt;

  assign run        = (state_q == ST_RUN) && !rst;
  assign redirect   = run && br_taken;
  assign credit     = {1'b0, count} + {1'b0, outstanding};
  assign imem_req   = run && !halt_seen && !br_taken && (credit < (CW+1)'(DEPTH));
  assign imem_addr  = pc_q;
  assign accept     = imem_req && imem_ready;

  // A response with nothing in flight is a protocol violation and is dropped.
  assign rsp        = imem_rvalid && (outstanding != '0) && !rst;
  assign push       = rsp && (drop == '0) && !redirect;
  assign rdata_halt = (imem_rdata[DATA_W-1 -: OPCODE_W] == HALT_OP);

  assign {if_pc, if_instr} = head;
  assign if_valid   = run && !q_empty;
  assign head_halt  = (if_instr[DATA_W-1 -: OPCODE_W] == HALT_OP);
  assign pop        = if_valid && id_ready && !redirect;
  assign hlt        = (state_q == ST_HALTED) && !rst;

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && pop && head_halt) state_d = ST_HALTED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      halt_seen   <= 1'b0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding + cnt_t'(accept) - cnt_t'(rsp);
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc_q      <= br_target;
        resp_pc   <= br_target;
        drop      <= outstanding - cnt_t'(rsp);
        halt_seen <= 1'b0;
      end else begin
        if (accept)                pc_q <= pc_q + ADDR_W'(PC_STEP);
        if (rsp && drop != '0)     drop <= drop - cnt_t'(1);
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(PC_STEP);
          if (rdata_halt) halt_seen <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && outstanding == '0));
      assert (!(push && q_full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata  = '0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        hlt;

  int          checks   = 0;
  int          failures = 0;
  int          mem_lat  = 1;
  logic [15:0] halt_addr = 16'hFFFF;
  int          cyc = 0;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .hlt         (hlt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    return (a == halt_addr) ? 16'hF000 : {4'h1, a[11:0]};
  endfunction

  // Memory: accepts at the edge, answers mem_lat cycles later, in order, one per cycle.
  always begin
    @(posedge clk);
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_rvalid && pend.size() > 0) pend.delete(0);
      if (imem_req && imem_ready) pend.push_back('{imem_addr, cyc + mem_lat});
    end
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nx();
    nx();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b1; br_taken = 1'b0; br_target = '0; imem_ready = 1'b1;

    // Reset state
    nx(); #2;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_hlt", hlt, 0);

    // 1: sequential stream, 1-cycle memory
    nx(); rst = 1'b0; #2;
    chk("t1_first_req", imem_req, 1);
    chk("t1_first_addr", imem_addr, 0);
    nx(); #2;
    chk("t1_c1_valid", if_valid, 0);
    for (int k = 0; k < 4; k++) begin
      nx(); #2;
      chk("t1_valid", if_valid, 1);
      chk("t1_pc", if_pc, 2 * k);
      chk("t1_instr", if_instr, 16'h1000 + 2 * k);
    end

    // 2: decoder stalled, credit limit of 4
    id_ready = 1'b0;
    do_reset(); #2;
    chk("t2_req0", imem_req, 1);
    chk("t2_addr0", imem_addr, 0);
    for (int k = 1; k < 4; k++) begin
      nx(); #2;
      chk("t2_req", imem_req, 1);
      chk("t2_addr", imem_addr, 2 * k);
    end
    nx(); #2;
    chk("t2_c4_noreq", imem_req, 0);
    nx(); #2;
    chk("t2_c5_noreq", imem_req, 0);
    chk("t2_c5_pc", if_pc, 0);
    nx(); id_ready = 1'b1; #2;
    chk("t2_c6_noreq", imem_req, 0);
    nx(); #2;
    chk("t2_resume_req", imem_req, 1);
    chk("t2_resume_addr", imem_addr, 16'h0008);
    chk("t2_c7_pc", if_pc, 2);

    // 3: redirect with two stale responses in flight, 3-cycle memory
    mem_lat = 3;
    do_reset(); #2;
    chk("t3_addr0", imem_addr, 0);
    nx(); #2;
    chk("t3_addr1", imem_addr, 2);
    nx(); br_taken = 1'b1; br_target = 16'h0040; #2;
    chk("t3_br_noreq", imem_req, 0);
    nx(); br_taken = 1'b0; #2;
    chk("t3_tgt_req", imem_req, 1);
    chk("t3_tgt_addr", imem_addr, 16'h0040);
    chk("t3_c3_valid", if_valid, 0);
    for (int k = 4; k < 7; k++) begin
      nx(); #2;
      chk("t3_drop_valid", if_valid, 0);
    end
    nx(); #2;
    chk("t3_valid", if_valid, 1);
    chk("t3_pc", if_pc, 16'h0040);
    chk("t3_instr", if_instr, 16'h1040);
    nx(); #2;
    chk("t3_pc_next", if_pc, 16'h0042);

    // 4: HALT at 0x000A
    mem_lat = 1; halt_addr = 16'h000A;
    do_reset();
    repeat (6) nx();
    #2;
    chk("t4_c6_pc", if_pc, 16'h0008);
    chk("t4_c6_addr", imem_addr, 16'h000C);
    nx(); #2;
    chk("t4_blocked", imem_req, 0);
    chk("t4_halt_pc", if_pc, 16'h000A);
    chk("t4_halt_instr", if_instr, 16'hF000);
    chk("t4_hlt_before", hlt, 0);
    nx(); #2;
    chk("t4_hlt", hlt, 1);
    chk("t4_valid_off", if_valid, 0);
    chk("t4_noreq", imem_req, 0);
    nx(); br_taken = 1'b1; br_target = 16'h0000; #2;
    chk("t4_br_hlt", hlt, 1);
    nx(); br_taken = 1'b0; #2;
    chk("t4_br_noreq", imem_req, 0);
    nx(); br_taken = 1'b1; #2;
    nx(); br_taken = 1'b0; #2;
    chk("t4_hlt_sticky", hlt, 1);
    chk("t4_noreq_sticky", imem_req, 0);

    // 5: HALT fetched then redirected before it is popped
    halt_addr = 16'h0004; id_ready = 1'b0;
    do_reset();
    repeat (4) nx();
    #2;
    chk("t5_halt_block", imem_req, 0);
    nx(); br_taken = 1'b1; br_target = 16'h0080; #2;
    nx(); br_taken = 1'b0; id_ready = 1'b1; #2;
    chk("t5_tgt_req", imem_req, 1);
    chk("t5_tgt_addr", imem_addr, 16'h0080);
    chk("t5_valid_flushed", if_valid, 0);
    chk("t5_hlt", hlt, 0);
    nx(); #2;
    chk("t5_addr_next", imem_addr, 16'h0082);
    nx(); #2;
    chk("t5_pc", if_pc, 16'h0080);
    chk("t5_instr", if_instr, 16'h1080);
    chk("t5_hlt_after", hlt, 0);

    // 6: reset mid-flight (2 outstanding, 2 queued)
    halt_addr = 16'hFFFF; mem_lat = 3; id_ready = 1'b0;
    do_reset();
    repeat (4) nx();
    #2;
    chk("t6_pre_noreq", imem_req, 0);
    chk("t6_pre_valid", if_valid, 1);
    nx(); rst = 1'b1; #2;
    chk("t6_rst_valid", if_valid, 0);
    chk("t6_rst_req", imem_req, 0);
    nx(); rst = 1'b0; #2;
    chk("t6_post_valid", if_valid, 0);
    chk("t6_post_req", imem_req, 1);
    chk("t6_post_addr", imem_addr, 0);
    repeat (2) nx();
    #2;
    chk("t6_c2_req", imem_req, 1);
    chk("t6_c2_addr", imem_addr, 4);
    nx(); #2;
    chk("t6_c3_addr", imem_addr, 6);
    nx(); #2;
    chk("t6_c4_noreq", imem_req, 0);
    chk("t6_c4_pc", if_pc, 0);
    chk("t6_c4_valid", if_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
